// File: rtl/led_pattern_gen.sv
// LED drive generator: static, blink, PWM and breathing patterns from shadowed cfg fields.
// Define LED_ACTIVE_LOW_EN to drive inverted LED pins (reset value all-ones).
module led_pattern_gen #(
    parameter int NUM_LED  = 8,
    parameter int TICK_DIV = 250,
    parameter int BLINK_W  = 16
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [NUM_LED-1:0] cfg_mask,
    input  logic [1:0]         cfg_mode,
    input  logic [7:0]         cfg_duty,
    input  logic [BLINK_W-1:0] cfg_half,
    input  logic               cfg_load,
    output logic [NUM_LED-1:0] LED,
    output logic               tick,
    output logic               phase
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [NUM_LED-1:0] LED_POL = '1;
`else
    localparam logic [NUM_LED-1:0] LED_POL = '0;
`endif

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'b00,
        MODE_BLINK   = 2'b01,
        MODE_PWM     = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_t;

    logic [NUM_LED-1:0] mask_sh;
    mode_t              mode_sh;
    logic [7:0]         duty_sh;
    logic [BLINK_W-1:0] half_sh;

    logic [PRE_W-1:0]   pre_cnt;
    logic [7:0]         pwm_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [7:0]         br_duty;
    logic               br_down;

    logic               mode_change;
    logic [BLINK_W-1:0] half_last;
    logic [7:0]         duty_eff;
    logic               pwm_on;
    logic               gate;

    assign mode_change = cfg_load && (mode_t'(cfg_mode) != mode_sh);
    // A zero half-period behaves as one tick per phase.
    assign half_last   = (half_sh == '0) ? '0 : half_sh - 1'b1;
    assign duty_eff    = (mode_sh == MODE_BREATHE) ? br_duty : duty_sh;
    assign pwm_on      = (pwm_cnt < duty_eff);

    always_comb begin
        gate = 1'b1;
        case (mode_sh)
            MODE_STATIC:  gate = 1'b1;
            MODE_BLINK:   gate = phase;
            MODE_PWM:     gate = pwm_on;
            MODE_BREATHE: gate = pwm_on;
            default:      gate = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_sh <= '0;
            mode_sh <= MODE_STATIC;
            duty_sh <= '0;
            half_sh <= '0;
        end else if (cfg_load) begin
            mask_sh <= cfg_mask;
            mode_sh <= mode_t'(cfg_mode);
            duty_sh <= cfg_duty;
            half_sh <= cfg_half;
        end
    end

    // Prescaler is free-running and deliberately untouched by mode changes.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (pre_cnt == PRE_LAST);
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            br_duty   <= '0;
            br_down   <= 1'b0;
        end else if (mode_change) begin
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            br_duty   <= '0;
            br_down   <= 1'b0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (blink_cnt == half_last) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            // Triangle ramp steps once per PWM period; the ends turn without repeating.
            if (pwm_cnt == 8'hFF) begin
                if (!br_down) begin
                    if (br_duty == 8'hFF) begin
                        br_down <= 1'b1;
                        br_duty <= 8'hFE;
                    end else begin
                        br_duty <= br_duty + 1'b1;
                    end
                end else begin
                    if (br_duty == 8'h00) begin
                        br_down <= 1'b0;
                        br_duty <= 8'h01;
                    end else begin
                        br_duty <= br_duty - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            LED <= LED_POL;
        end else begin
            LED <= (mask_sh & {NUM_LED{gate}}) ^ LED_POL;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with TICK_DIV=4; expectations are hand-derived.
// Build with LED_ACTIVE_LOW_EN defined to check the inverted LED polarity.
module tb_led_pattern_gen;

    localparam int NUM_LED  = 8;
    localparam int TICK_DIV = 4;
    localparam int BLINK_W  = 16;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [7:0] POL = 8'hFF;
`else
    localparam logic [7:0] POL = 8'h00;
`endif

    logic               sys_clk = 1'b0;
    logic               rst_n   = 1'b0;
    logic [7:0]         cfg_mask = '0;
    logic [1:0]         cfg_mode = '0;
    logic [7:0]         cfg_duty = '0;
    logic [15:0]        cfg_half = '0;
    logic               cfg_load = 1'b0;
    logic [7:0]         LED;
    logic               tick;
    logic               phase;

    int tests_run = 0;
    int fails     = 0;
    logic [15:0] exp_q[$];

    led_pattern_gen #(
        .NUM_LED (NUM_LED),
        .TICK_DIV(TICK_DIV),
        .BLINK_W (BLINK_W)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .cfg_mask(cfg_mask),
        .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty),
        .cfg_half(cfg_half),
        .cfg_load(cfg_load),
        .LED     (LED),
        .tick    (tick),
        .phase   (phase)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; the following posedge is the load edge. Returns at the next negedge
    // with cfg_* scrambled so any capture without cfg_load shows up.
    task automatic do_load(input logic [7:0] m, input logic [1:0] md,
                           input logic [7:0] d, input logic [15:0] h);
        cfg_mask = m;
        cfg_mode = md;
        cfg_duty = d;
        cfg_half = h;
        cfg_load = 1'b1;
        @(negedge sys_clk);
        cfg_load = 1'b0;
        cfg_mask = 8'($urandom_range(0, 255));
        cfg_mode = 2'($urandom_range(0, 3));
        cfg_duty = 8'($urandom_range(0, 255));
        cfg_half = 16'($urandom_range(0, 65535));
    endtask

    task automatic wait_change(input int limit, output int cycles, output bit ok);
        logic [7:0] prev;
        prev   = LED;
        cycles = 0;
        ok     = 1'b0;
        while (cycles < limit && !ok) begin
            @(negedge sys_clk);
            cycles++;
            if (LED !== prev) ok = 1'b1;
        end
    endtask

    task automatic wait_led(input logic [7:0] val, input int limit, output bit ok);
        int n;
        n  = 0;
        ok = (LED === val);
        while (n < limit && !ok) begin
            @(negedge sys_clk);
            n++;
            if (LED === val) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        tests_run++;
        if (LED !== POL) begin
            fails++;
            $display("FAIL reset_led: got %h expected %h", LED, POL);
        end
        tests_run++;
        if (tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_tick: got %b expected 0", tick);
        end
        tests_run++;
        if (phase !== 1'b0) begin
            fails++;
            $display("FAIL reset_phase: got %b expected 0", phase);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_tick;
        logic exp_t;
        for (int i = 1; i <= 12; i++) begin
            @(negedge sys_clk);
            exp_t = ((i % TICK_DIV) == 0);
            tests_run++;
            if (tick !== exp_t) begin
                fails++;
                $display("FAIL tick_cycle%0d: got %b expected %b", i, tick, exp_t);
            end
        end
    endtask

    task automatic test_static;
        int bad;
        do_load(8'hA5, 2'b00, 8'h00, 16'd0);
        tests_run++;
        if (LED !== POL) begin
            fails++;
            $display("FAIL static_latency: got %h expected %h", LED, POL);
        end
        @(negedge sys_clk);
        tests_run++;
        if (LED !== (8'hA5 ^ POL)) begin
            fails++;
            $display("FAIL static_value: got %h expected %h", LED, 8'hA5 ^ POL);
        end
        bad = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (LED !== (8'hA5 ^ POL)) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL static_hold: %0d bad samples, expected 0", bad);
        end
    endtask

    task automatic check_blink(input logic [15:0] h, input int exp_period);
        int  c;
        bit  ok;
        do_load(8'hFF, 2'b01, 8'h00, h);
        for (int s = 0; s < 2; s++) begin
            wait_change(40, c, ok);
            if (!ok) begin
                tests_run++;
                fails++;
                $display("FAIL blink_h%0d_align: no LED change within 40 cycles", h);
            end
        end
        for (int p = 0; p < 2; p++) begin
            wait_change(40, c, ok);
            tests_run++;
            if (!ok || c != exp_period) begin
                fails++;
                $display("FAIL blink_h%0d_period: got %0d cycles expected %0d", h, c, exp_period);
            end
            tests_run++;
            if (LED !== POL && LED !== (8'hFF ^ POL)) begin
                fails++;
                $display("FAIL blink_h%0d_value: got %h expected %h or %h", h, LED, POL, 8'hFF ^ POL);
            end
            tests_run++;
            if (phase !== (LED === (8'hFF ^ POL))) begin
                fails++;
                $display("FAIL blink_h%0d_phase: got %b with LED %h", h, phase, LED);
            end
        end
    endtask

    task automatic test_blink;
        check_blink(16'd3, 12);
        do_load(8'hFF, 2'b00, 8'h00, 16'd0);
        repeat (3) @(negedge sys_clk);
        check_blink(16'd0, 4);
    endtask

    task automatic test_pwm;
        bit ok;
        int run, on_cnt, bad;
        do_load(8'h0F, 2'b10, 8'd64, 16'd0);
        wait_led(POL, 1100, ok);
        if (ok) wait_led(8'h0F ^ POL, 1100, ok);
        tests_run++;
        if (!ok) begin
            fails++;
            $display("FAIL pwm_start: on-phase not seen, LED %h", LED);
        end
        run = 0;
        while (LED === (8'h0F ^ POL) && run < 1100) begin
            run++;
            @(negedge sys_clk);
        end
        tests_run++;
        if (run != 256) begin
            fails++;
            $display("FAIL pwm_run64: got %0d on cycles expected 256", run);
        end
        on_cnt = 0;
        bad    = 0;
        for (int i = 0; i < 1024; i++) begin
            if (LED === (8'h0F ^ POL)) on_cnt++;
            else if (LED !== POL) bad++;
            @(negedge sys_clk);
        end
        tests_run++;
        if (on_cnt != 256) begin
            fails++;
            $display("FAIL pwm_window64: got %0d on cycles expected 256", on_cnt);
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL pwm_values: %0d samples outside {%h,%h}", bad, POL, 8'h0F ^ POL);
        end
        do_load(8'h0F, 2'b10, 8'd0, 16'd0);
        @(negedge sys_clk);
        on_cnt = 0;
        repeat (1100) begin
            @(negedge sys_clk);
            if (LED !== POL) on_cnt++;
        end
        tests_run++;
        if (on_cnt != 0) begin
            fails++;
            $display("FAIL pwm_duty0: got %0d non-dark samples expected 0", on_cnt);
        end
    endtask

    task automatic test_breathe_switch;
        bit ok;
        int run, n;
        logic [15:0] exp_run;
        do_load(8'h0F, 2'b11, 8'd0, 16'd0);
        exp_q.delete();
        for (int k = 1; k <= 4; k++) exp_q.push_back(16'(4 * k));
        while (exp_q.size() > 0) begin
            exp_run = exp_q.pop_front();
            wait_led(8'h0F ^ POL, 2100, ok);
            run = 0;
            while (ok && LED === (8'h0F ^ POL) && run < 300) begin
                run++;
                @(negedge sys_clk);
            end
            tests_run++;
            if (!ok || run != int'(exp_run)) begin
                fails++;
                $display("FAIL breathe_run: got %0d on cycles expected %0d", run, exp_run);
            end
        end
        n = 0;
        while (!(phase === 1'b1 && tick === 1'b0) && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        tests_run++;
        if (n >= 50) begin
            fails++;
            $display("FAIL switch_setup: phase=1 with tick=0 not seen in 50 cycles");
        end
        do_load(8'hFF, 2'b01, 8'h00, 16'd3);
        tests_run++;
        if (phase !== 1'b0) begin
            fails++;
            $display("FAIL switch_phase_clear: got %b expected 0", phase);
        end
        n = 0;
        repeat (8) begin
            @(negedge sys_clk);
            if (LED !== POL) n++;
        end
        tests_run++;
        if (n != 0) begin
            fails++;
            $display("FAIL switch_blink_restart: %0d lit samples in off half, expected 0", n);
        end
        wait_led(8'hFF ^ POL, 12, ok);
        tests_run++;
        if (!ok) begin
            fails++;
            $display("FAIL switch_first_on: LED %h expected %h within 12 cycles", LED, 8'hFF ^ POL);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        n = 0;
        while (!(LED === (8'hFF ^ POL) && tick === 1'b1) && n < 60) begin
            @(negedge sys_clk);
            n++;
        end
        tests_run++;
        if (n >= 60) begin
            fails++;
            $display("FAIL rstmid_setup: lit LED with tick not seen in 60 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (LED !== POL) begin
            fails++;
            $display("FAIL rstmid_led: got %h expected %h", LED, POL);
        end
        tests_run++;
        if (tick !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_tick: got %b expected 0", tick);
        end
        tests_run++;
        if (phase !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_phase: got %b expected 0", phase);
        end
        @(negedge sys_clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge sys_clk);
            if (LED !== POL) n++;
        end
        tests_run++;
        if (n != 0) begin
            fails++;
            $display("FAIL rstmid_hold: %0d lit samples before load, expected 0", n);
        end
        do_load(8'h01, 2'b00, 8'h00, 16'd0);
        @(negedge sys_clk);
        tests_run++;
        if (LED !== (8'h01 ^ POL)) begin
            fails++;
            $display("FAIL rstmid_reload: got %h expected %h", LED, 8'h01 ^ POL);
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_static();
        test_blink();
        test_pwm();
        test_breathe_switch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
